// File: rtl/l1cache_pkg.sv
// Shared definitions for the direct-mapped multi-word-line L1 cache.
// FSM state encoding and word-address field slicing helpers.
package l1cache_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    CHECK      = 3'd2,
    WRITE      = 3'd3,
    REFILL     = 3'd4,
    REFILL_GAP = 3'd5
  } state_t;

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int addr_bits,
                                         input int index_bits, input int offset_bits);
    logic [31:0] mask;
    mask = (addr_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_bits) - 32'd1);
    return (addr & mask) >> (index_bits + offset_bits);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int index_bits,
                                           input int offset_bits);
    return (addr >> offset_bits) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] offset_of(input logic [31:0] addr, input int offset_bits);
    return addr & ((32'd1 << offset_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/l1cache_sp_ram.sv
// Single-port RAM with write enable and registered read; used for tag and data storage.
module l1cache_sp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/l1cache_line.sv
// Direct-mapped write-through L1 with multi-word lines, line refill over single-word
// SDRAM transactions, one-cycle flush and uncached passthrough above CACHEABLE_LIMIT.
module l1cache_line
  import l1cache_pkg::*;
#(
  parameter int          INDEX_BITS      = 8,
  parameter int          OFFSET_BITS     = 2,
  parameter int          ADDR_BITS       = 24,
  parameter logic [31:0] CACHEABLE_LIMIT = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] l2_addr,
  input  logic [31:0] l2_data,
  input  logic        l2_we,
  input  logic        l2_start,
  output logic [31:0] l2_q,
  output logic        l2_done,
  output logic [31:0] sdc_addr,
  output logic [31:0] sdc_data,
  output logic        sdc_we,
  output logic        sdc_start,
  input  logic [31:0] sdc_q,
  input  logic        sdc_done,
  output logic        busy
);

  localparam int LINES      = 2 ** INDEX_BITS;
  localparam int LINE_WORDS = 2 ** OFFSET_BITS;
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int OFF_W      = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
  localparam int DADDR_W    = INDEX_BITS + OFFSET_BITS;

  state_t             r_state;
  logic [31:0]        r_addr, r_data;
  logic               r_we, r_start_prev, r_hit, r_flush_pending;
  logic [OFF_W-1:0]   r_k;
  logic [LINES-1:0]   r_valid;
  logic [31:0]        r_l2_q, r_sdc_addr, r_sdc_data;
  logic               r_l2_done, r_sdc_we, r_sdc_start;

  logic [TAG_BITS-1:0]   w_tag, w_tag_q;
  logic [INDEX_BITS-1:0] w_idx;
  logic [OFF_W-1:0]      w_off, w_word;
  logic [DADDR_W-1:0]    w_daddr;
  logic [31:0]           w_data_q, w_data_wdata, w_line_base;
  logic                  w_hit, w_accept, w_pass, w_last, w_to_idle, w_tag_we, w_data_we;

  assign w_tag  = TAG_BITS'(tag_of(r_addr, ADDR_BITS, INDEX_BITS, OFFSET_BITS));
  assign w_idx  = INDEX_BITS'(index_of(r_addr, INDEX_BITS, OFFSET_BITS));
  assign w_off  = OFF_W'(offset_of(r_addr, OFFSET_BITS));
  assign w_line_base = 32'({w_tag, w_idx}) << OFFSET_BITS;

  assign w_hit    = r_valid[w_idx] && (w_tag_q == w_tag);
  assign w_last   = (r_k == OFF_W'(LINE_WORDS - 1));
  assign w_accept = (r_state == IDLE) && l2_start && !r_start_prev && (l2_addr < CACHEABLE_LIMIT);
  assign w_to_idle = ((r_state == CHECK) && !r_we && w_hit) ||
                     ((r_state == WRITE) && sdc_done) ||
                     ((r_state == REFILL) && sdc_done && w_last);

  // Refill writes walk the line by k; every other access uses the request offset.
  assign w_word       = (r_state == REFILL) ? r_k : w_off;
  assign w_daddr      = DADDR_W'((32'(w_idx) << OFFSET_BITS) | 32'(w_word));
  assign w_data_we    = ((r_state == REFILL) && sdc_done) || ((r_state == WRITE) && sdc_done && r_hit);
  assign w_data_wdata = (r_state == REFILL) ? sdc_q : r_data;
  assign w_tag_we     = (r_state == REFILL) && sdc_done && w_last;

  l1cache_sp_ram #(.WIDTH(TAG_BITS), .DEPTH(LINES)) u_tag_ram (
    .clk(clk), .i_we(w_tag_we), .i_addr(w_idx), .i_wdata(w_tag), .o_rdata(w_tag_q)
  );

  l1cache_sp_ram #(.WIDTH(32), .DEPTH(LINES * LINE_WORDS)) u_data_ram (
    .clk(clk), .i_we(w_data_we), .i_addr(w_daddr), .i_wdata(w_data_wdata), .o_rdata(w_data_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_data          <= '0;
      r_we            <= 1'b0;
      r_start_prev    <= 1'b0;
      r_hit           <= 1'b0;
      r_flush_pending <= 1'b0;
      r_k             <= '0;
      r_valid         <= '0;
      r_l2_q          <= '0;
      r_l2_done       <= 1'b0;
      r_sdc_addr      <= '0;
      r_sdc_data      <= '0;
      r_sdc_we        <= 1'b0;
      r_sdc_start     <= 1'b0;
    end else begin
      r_start_prev <= l2_start;
      r_l2_done    <= 1'b0;
      if (flush && r_state != IDLE) r_flush_pending <= 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_addr  <= l2_addr;
          r_data  <= l2_data;
          r_we    <= l2_we;
          r_state <= LOOKUP;
        end
        LOOKUP: r_state <= CHECK;
        CHECK: begin
          r_hit <= w_hit;
          if (r_we) begin
            r_sdc_we    <= 1'b1;
            r_sdc_data  <= r_data;
            r_sdc_addr  <= r_addr;
            r_sdc_start <= 1'b1;
            r_state     <= WRITE;
          end else if (w_hit) begin
            r_l2_q    <= w_data_q;
            r_l2_done <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_k         <= '0;
            r_sdc_we    <= 1'b0;
            r_sdc_addr  <= w_line_base;
            r_sdc_start <= 1'b1;
            r_state     <= REFILL;
          end
        end
        WRITE: if (sdc_done) begin
          r_sdc_start <= 1'b0;
          r_sdc_we    <= 1'b0;
          r_l2_done   <= 1'b1;
          r_state     <= IDLE;
        end
        REFILL: if (sdc_done) begin
          r_sdc_start <= 1'b0;
          if (r_k == w_off) r_l2_q <= sdc_q;
          if (w_last) begin
            r_valid[w_idx] <= 1'b1;
            r_l2_done      <= 1'b1;
            r_state        <= IDLE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= REFILL_GAP;
          end
        end
        REFILL_GAP: begin
          r_sdc_addr  <= w_line_base | 32'(r_k);
          r_sdc_start <= 1'b1;
          r_state     <= REFILL;
        end
        default: r_state <= IDLE;
      endcase
      // Placed last so a deferred flush overrides the valid bit set by the finishing refill.
      if ((r_state == IDLE && flush) || (w_to_idle && (flush || r_flush_pending))) begin
        r_valid         <= '0;
        r_flush_pending <= 1'b0;
      end
    end
  end

  assign w_pass    = (r_state == IDLE) && (l2_addr >= CACHEABLE_LIMIT);
  assign sdc_addr  = w_pass ? l2_addr  : r_sdc_addr;
  assign sdc_data  = w_pass ? l2_data  : r_sdc_data;
  assign sdc_we    = w_pass ? l2_we    : r_sdc_we;
  assign sdc_start = w_pass ? l2_start : r_sdc_start;
  assign l2_q      = w_pass ? sdc_q    : r_l2_q;
  assign l2_done   = w_pass ? sdc_done : r_l2_done;
  assign busy      = (r_state != IDLE);

endmodule
